// File: rtl/dcache_pkg.sv
// Shared types and default geometry for the write-through data cache.
package dcache_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      REFILL = 2'd1,
      WRITE  = 2'd2,
      WDONE  = 2'd3
   } state_e;

   localparam int DC_LINES  = 16;
   localparam int DC_WPL    = 4;
   localparam int DC_ADDR_W = 32;
   localparam int DC_OFF_W  = $clog2(DC_WPL);
   localparam int DC_IDX_W  = $clog2(DC_LINES);
   localparam int DC_TAG_W  = DC_ADDR_W - DC_IDX_W - DC_OFF_W - 2;

endpackage

// File: rtl/dcache_array.sv
// Valid/tag/data storage: combinational read and hit compare, one write port.
module dcache_array
   import dcache_pkg::*;
#(
   parameter int LINES = DC_LINES,
   parameter int WPL   = DC_WPL,
   parameter int OFF_W = DC_OFF_W,
   parameter int IDX_W = DC_IDX_W,
   parameter int TAG_W = DC_TAG_W
) (
   input  logic             clk_i,
   input  logic             clr_i,
   input  logic [IDX_W-1:0] idx_i,
   input  logic [OFF_W-1:0] off_i,
   input  logic [TAG_W-1:0] tag_i,
   output logic [31:0]      rdata_o,
   output logic             hit_o,
   input  logic             wr_word_i,
   input  logic [OFF_W-1:0] wr_off_i,
   input  logic [31:0]      wr_data_i,
   input  logic             set_line_i
);

   logic [LINES-1:0] valid_q;
   logic [TAG_W-1:0] tag_q  [LINES];
   logic [31:0]      data_q [LINES][WPL];

   // Only the valid bits are cleared; tag and data contents are don't-care until revalidated.
   always_ff @(posedge clk_i) begin
      if (clr_i)
         valid_q <= '0;
      else if (set_line_i)
         valid_q[idx_i] <= 1'b1;
   end

   always_ff @(posedge clk_i) begin
      if (set_line_i)
         tag_q[idx_i] <= tag_i;
      if (wr_word_i)
         data_q[idx_i][wr_off_i] <= wr_data_i;
   end

   assign hit_o   = valid_q[idx_i] & (tag_q[idx_i] == tag_i);
   assign rdata_o = data_q[idx_i][off_i];

endmodule

// File: rtl/dcache_wt.sv
// Direct-mapped write-through, no-write-allocate data cache with word-serial refill.
module dcache_wt
   import dcache_pkg::*;
#(
   parameter int LINES          = DC_LINES,
   parameter int WORDS_PER_LINE = DC_WPL,
   parameter int ADDR_W         = DC_ADDR_W
) (
   input  logic              clk_i,
   input  logic              reset_i,
   input  logic              cpu_rd_i,
   input  logic              cpu_wr_i,
   input  logic [ADDR_W-1:0] cpu_addr_i,
   input  logic [31:0]       cpu_wdata_i,
   output logic [31:0]       cpu_rdata_o,
   output logic              stall_o,
   output logic              mem_req_o,
   output logic              mem_we_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [31:0]       mem_wdata_o,
   input  logic              mem_ack_i,
   input  logic [31:0]       mem_rdata_i
);

   localparam int OFF_W = $clog2(WORDS_PER_LINE);
   localparam int IDX_W = $clog2(LINES);
   localparam int TAG_W = ADDR_W - IDX_W - OFF_W - 2;
   localparam logic [OFF_W-1:0] LAST_WORD = OFF_W'(WORDS_PER_LINE - 1);

   logic [OFF_W-1:0] off;
   logic [IDX_W-1:0] idx;
   logic [TAG_W-1:0] tag;
   logic             unused_byte_sel;

   assign off             = cpu_addr_i[OFF_W+1:2];
   assign idx             = cpu_addr_i[OFF_W+IDX_W+1:OFF_W+2];
   assign tag             = cpu_addr_i[ADDR_W-1:OFF_W+IDX_W+2];
   assign unused_byte_sel = ^cpu_addr_i[1:0];

   state_e            state_q, state_d;
   logic [OFF_W-1:0]  cnt_q, cnt_d, cnt_nxt;
   logic              mem_req_q, mem_req_d;
   logic              mem_we_q, mem_we_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [31:0]       mem_wdata_q, mem_wdata_d;

   logic              stall_c;
   logic [31:0]       rdata_c;
   logic              wr_word_c, set_line_c;
   logic [OFF_W-1:0]  wr_off_c;
   logic [31:0]       wr_data_c;
   logic [31:0]       arr_rdata;
   logic              hit;

   dcache_array #(
      .LINES (LINES),
      .WPL   (WORDS_PER_LINE),
      .OFF_W (OFF_W),
      .IDX_W (IDX_W),
      .TAG_W (TAG_W)
   ) u_array (
      .clk_i      (clk_i),
      .clr_i      (reset_i),
      .idx_i      (idx),
      .off_i      (off),
      .tag_i      (tag),
      .rdata_o    (arr_rdata),
      .hit_o      (hit),
      .wr_word_i  (wr_word_c & ~reset_i),
      .wr_off_i   (wr_off_c),
      .wr_data_i  (wr_data_c),
      .set_line_i (set_line_c & ~reset_i)
   );

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
      end
   end

   assign cnt_nxt = cnt_q + OFF_W'(1);

   // Memory-side outputs are loaded one state ahead so they never depend on mem_ack combinationally.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      mem_req_d   = mem_req_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      stall_c     = 1'b0;
      rdata_c     = '0;
      wr_word_c   = 1'b0;
      set_line_c  = 1'b0;
      wr_off_c    = off;
      wr_data_c   = cpu_wdata_i;
      case (state_q)
         IDLE: begin
            if (cpu_wr_i) begin
               stall_c     = 1'b1;
               state_d     = WRITE;
               mem_req_d   = 1'b1;
               mem_we_d    = 1'b1;
               mem_addr_d  = {cpu_addr_i[ADDR_W-1:2], 2'b00};
               mem_wdata_d = cpu_wdata_i;
            end else if (cpu_rd_i) begin
               if (hit) begin
                  rdata_c = arr_rdata;
               end else begin
                  stall_c    = 1'b1;
                  state_d    = REFILL;
                  cnt_d      = '0;
                  mem_req_d  = 1'b1;
                  mem_we_d   = 1'b0;
                  mem_addr_d = {tag, idx, {OFF_W{1'b0}}, 2'b00};
               end
            end
         end
         REFILL: begin
            stall_c = 1'b1;
            if (mem_ack_i) begin
               wr_word_c = 1'b1;
               wr_off_c  = cnt_q;
               wr_data_c = mem_rdata_i;
               if (cnt_q == LAST_WORD) begin
                  set_line_c = 1'b1;
                  state_d    = IDLE;
                  cnt_d      = '0;
                  mem_req_d  = 1'b0;
               end else begin
                  cnt_d      = cnt_nxt;
                  mem_addr_d = {tag, idx, cnt_nxt, 2'b00};
               end
            end
         end
         WRITE: begin
            stall_c = 1'b1;
            if (mem_ack_i) begin
               wr_word_c = hit;
               state_d   = WDONE;
               mem_req_d = 1'b0;
               mem_we_d  = 1'b0;
            end
         end
         WDONE: begin
            // One unstalled cycle lets the pipeline retire the store before IDLE looks at it again.
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign stall_o     = stall_c & ~reset_i;
   assign cpu_rdata_o = reset_i ? 32'd0 : rdata_c;
   assign mem_req_o   = mem_req_q;
   assign mem_we_o    = mem_we_q;
   assign mem_addr_o  = mem_addr_q;
   assign mem_wdata_o = mem_wdata_q;

endmodule

// File: tb/tb_dcache_wt.sv
// Directed bench for dcache_wt with a word-addressed memory responder.
module tb_dcache_wt;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        cpu_rd = 1'b0;
   logic        cpu_wr = 1'b0;
   logic [31:0] cpu_addr = '0;
   logic [31:0] cpu_wdata = '0;
   logic [31:0] cpu_rdata;
   logic        stall;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_ack = 1'b0;
   logic [31:0] mem_rdata = '0;

   int n_checks = 0;
   int n_fail   = 0;

   logic [31:0] tmem [0:1023];
   int          ack_delay  = 0;
   int          wait_cnt   = 0;
   int          ack_total  = 0;
   int          req_cycles = 0;
   logic [31:0] ack_addr [$];

   dcache_wt dut (
      .clk_i       (clk),
      .reset_i     (reset),
      .cpu_rd_i    (cpu_rd),
      .cpu_wr_i    (cpu_wr),
      .cpu_addr_i  (cpu_addr),
      .cpu_wdata_i (cpu_wdata),
      .cpu_rdata_o (cpu_rdata),
      .stall_o     (stall),
      .mem_req_o   (mem_req),
      .mem_we_o    (mem_we),
      .mem_addr_o  (mem_addr),
      .mem_wdata_o (mem_wdata),
      .mem_ack_i   (mem_ack),
      .mem_rdata_i (mem_rdata)
   );

   always #5 clk = ~clk;

   // Memory: acks a request after ack_delay waiting cycles, one word per ack.
   always @(negedge clk) begin
      mem_ack = 1'b0;
      if (reset) begin
         wait_cnt = 0;
      end else if (mem_req) begin
         req_cycles++;
         if (wait_cnt == ack_delay) begin
            mem_ack  = 1'b1;
            wait_cnt = 0;
            ack_total++;
            ack_addr.push_back(mem_addr);
            if (mem_we) tmem[mem_addr[11:2]] = mem_wdata;
            else        mem_rdata = tmem[mem_addr[11:2]];
         end else begin
            wait_cnt++;
         end
      end
   end

   task automatic run_read(input logic [31:0] a, input int exp_stalls,
                           input logic [31:0] exp_data, input string nm);
      int n;
      @(negedge clk);
      cpu_rd = 1'b1; cpu_wr = 1'b0; cpu_addr = a;
      #1;
      n = 0;
      while (stall !== 1'b0 && n < 200) begin
         @(negedge clk); #1; n++;
      end
      n_checks++;
      if (n !== exp_stalls) begin
         n_fail++; $display("FAIL %s stall_cycles: got %0d expected %0d", nm, n, exp_stalls);
      end
      n_checks++;
      if (cpu_rdata !== exp_data) begin
         n_fail++; $display("FAIL %s rdata: got %h expected %h", nm, cpu_rdata, exp_data);
      end
      @(negedge clk);
      cpu_rd = 1'b0;
   endtask

   task automatic run_store(input logic [31:0] a, input logic [31:0] d, input logic also_rd,
                            input string nm);
      @(negedge clk);
      cpu_wr = 1'b1; cpu_rd = also_rd; cpu_addr = a; cpu_wdata = d;
      #1;
      n_checks++;
      if (stall !== 1'b1) begin
         n_fail++; $display("FAIL %s idle_stall: got %b expected 1", nm, stall);
      end
      @(negedge clk); #1;
      n_checks++;
      if ({mem_req, mem_we} !== 2'b11) begin
         n_fail++; $display("FAIL %s req_we: got %b expected 11", nm, {mem_req, mem_we});
      end
      n_checks++;
      if (mem_addr !== {a[31:2], 2'b00}) begin
         n_fail++; $display("FAIL %s mem_addr: got %h expected %h", nm, mem_addr, {a[31:2], 2'b00});
      end
      n_checks++;
      if (mem_wdata !== d) begin
         n_fail++; $display("FAIL %s mem_wdata: got %h expected %h", nm, mem_wdata, d);
      end
      @(negedge clk); #1;
      n_checks++;
      if ({stall, mem_req} !== 2'b00) begin
         n_fail++; $display("FAIL %s wdone: stall/req got %b expected 00", nm, {stall, mem_req});
      end
      @(negedge clk);
      cpu_wr = 1'b0; cpu_rd = 1'b0;
      #1;
      n_checks++;
      if (mem_req !== 1'b0) begin
         n_fail++; $display("FAIL %s no_rewrite: mem_req got %b expected 0", nm, mem_req);
      end
   endtask

   task automatic test_reset();
      cpu_rd = 1'b1; cpu_addr = 32'h100;
      #1;
      n_checks++;
      if ({stall, cpu_rdata} !== 33'd0) begin
         n_fail++; $display("FAIL reset_cycle: stall=%b rdata=%h expected 0/0", stall, cpu_rdata);
      end
      repeat (2) @(negedge clk);
      #1;
      n_checks++;
      if ({mem_req, mem_we, mem_addr, mem_wdata} !== 66'd0) begin
         n_fail++; $display("FAIL reset_mem_if: req=%b we=%b addr=%h wdata=%h expected zeros",
                            mem_req, mem_we, mem_addr, mem_wdata);
      end
      reset = 1'b0; cpu_rd = 1'b0;
   endtask

   task automatic test_miss_refill();
      logic [31:0] exp_a;
      ack_addr.delete();
      run_read(32'h100, 5, 32'hA0, "miss_refill");
      n_checks++;
      if (ack_addr.size() !== 4) begin
         n_fail++; $display("FAIL refill_words: got %0d expected 4", ack_addr.size());
      end
      for (int i = 0; i < 4 && i < ack_addr.size(); i++) begin
         exp_a = 32'h100 + 32'(4 * i);
         n_checks++;
         if (ack_addr[i] !== exp_a) begin
            n_fail++; $display("FAIL refill_addr%0d: got %h expected %h", i, ack_addr[i], exp_a);
         end
      end
   endtask

   task automatic test_hit();
      int r0;
      r0 = req_cycles;
      run_read(32'h108, 0, 32'hA2, "hit_0x108");
      n_checks++;
      if (req_cycles !== r0) begin
         n_fail++; $display("FAIL hit_no_req: got %0d req cycles expected 0", req_cycles - r0);
      end
   endtask

   task automatic test_store_hit();
      run_store(32'h104, 32'h55, 1'b0, "store_hit");
      run_read(32'h104, 0, 32'h55, "store_hit_reread");
   endtask

   task automatic test_store_miss();
      run_store(32'h200, 32'h1234_5678, 1'b0, "store_miss");
      n_checks++;
      if (tmem[32'h200 >> 2] !== 32'h1234_5678) begin
         n_fail++; $display("FAIL store_miss_mem: got %h expected 12345678", tmem[32'h200 >> 2]);
      end
      run_read(32'h200, 5, 32'h1234_5678, "store_miss_reread");
   endtask

   task automatic test_priority();
      run_store(32'h10C, 32'h77, 1'b1, "rd_wr_priority");
      run_read(32'h10C, 0, 32'h77, "priority_reread");
   endtask

   task automatic test_back_to_back();
      @(negedge clk);
      cpu_rd = 1'b1; cpu_addr = 32'h100;
      #1;
      n_checks++;
      if ({stall, cpu_rdata} !== {1'b0, 32'hA0}) begin
         n_fail++; $display("FAIL b2b_first: stall=%b rdata=%h expected 0/a0", stall, cpu_rdata);
      end
      @(negedge clk);
      cpu_addr = 32'h108;
      #1;
      n_checks++;
      if ({stall, cpu_rdata} !== {1'b0, 32'hA2}) begin
         n_fail++; $display("FAIL b2b_second: stall=%b rdata=%h expected 0/a2", stall, cpu_rdata);
      end
      @(negedge clk);
      cpu_rd = 1'b0;
      #1;
      n_checks++;
      if (cpu_rdata !== 32'd0) begin
         n_fail++; $display("FAIL idle_rdata: got %h expected 0", cpu_rdata);
      end
   endtask

   task automatic test_conflict();
      run_read(32'h500, 5, 32'hB0, "conflict_0x500");
      run_read(32'h100, 5, 32'hA0, "conflict_reread_0x100");
   endtask

   task automatic test_reset_mid_refill();
      int base;
      int n;
      ack_delay = 3;
      base = ack_total;
      @(negedge clk);
      cpu_rd = 1'b1; cpu_addr = 32'h300;
      #1;
      n = 0;
      while (ack_total - base < 2 && n < 100) begin
         @(negedge clk); #1; n++;
      end
      n_checks++;
      if (ack_total - base !== 2) begin
         n_fail++; $display("FAIL mid_refill_acks: got %0d expected 2", ack_total - base);
      end
      @(negedge clk); #1;
      n_checks++;
      if (mem_req !== 1'b1) begin
         n_fail++; $display("FAIL mid_refill_req: got %b expected 1", mem_req);
      end
      reset = 1'b1; cpu_rd = 1'b0;
      @(negedge clk); #1;
      n_checks++;
      if ({mem_req, stall} !== 2'b00) begin
         n_fail++; $display("FAIL reset_drop_req: req/stall got %b expected 00", {mem_req, stall});
      end
      reset = 1'b0;
      ack_addr.delete();
      run_read(32'h300, 17, tmem[32'h300 >> 2], "rst_reread_0x300");
      n_checks++;
      if (ack_addr.size() !== 4) begin
         n_fail++; $display("FAIL rst_refill_words: got %0d expected 4", ack_addr.size());
      end
      if (ack_addr.size() == 4) begin
         n_checks++;
         if ({ack_addr[0], ack_addr[3]} !== {32'h300, 32'h30C}) begin
            n_fail++; $display("FAIL rst_refill_addr: got %h..%h expected 300..30c",
                               ack_addr[0], ack_addr[3]);
         end
      end
      ack_delay = 0;
      run_read(32'h100, 5, 32'hA0, "post_reset_0x100");
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) tmem[i] = 32'hC000_0000 + 32'(i);
      for (int i = 0; i < 4; i++) begin
         tmem[(32'h100 >> 2) + i] = 32'hA0 + 32'(i);
         tmem[(32'h500 >> 2) + i] = 32'hB0 + 32'(i);
      end
      test_reset();
      test_miss_refill();
      test_hit();
      test_store_hit();
      test_priority();
      test_back_to_back();
      test_store_miss();
      test_conflict();
      test_reset_mid_refill();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/dcache_wt.md
Name: dcache_wt

Overview:
- Direct-mapped, write-through, no-write-allocate data cache between the processor's MEM stage and backing data memory.
- Takes the MEM-stage address, store data and read/write strobes, and returns load data.
- Drives the pipeline-wide stall signal, held high while a miss refill or store write-through is in progress.
- Refills 4-word lines from memory over a per-word req/ack handshake.

Parameters:
- LINES, 16, number of cache lines; power of two, ≥2.
- WORDS_PER_LINE, 4, fixed 32-bit words per line; power of two.
- ADDR_W, 32, byte address width.

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high reset
- cpu_rd  in  1  load request from MEM stage, held until stall low
- cpu_wr  in  1  store request from MEM stage, held until stall low
- cpu_addr  in  32  byte address; bits [1:0] ignored
- cpu_wdata  in  32  store data
- cpu_rdata  out  32  load data, valid when cpu_rd=1 and stall=0
- stall  out  1  freeze all pipeline registers
- mem_req  out  1  memory transfer request, held until mem_ack
- mem_we  out  1  1=write, 0=read
- mem_addr  out  32  word-aligned memory address
- mem_wdata  out  32  write data
- mem_ack  in  1  one-cycle pulse; one word transferred
- mem_rdata  in  32  read data, valid with mem_ack

Behaviour:
Reset and address fields:
- On reset: state=IDLE, all valid bits=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, refill counter=0.
- stall=0 and cpu_rdata=0 in the reset cycle. Tag/data contents are not reset.
- Address split: offset=addr[3:2], index=addr[3+log2(LINES):4], tag=remaining upper bits.
- hit = valid[index] & (tag_store[index]==tag), combinational.

States: IDLE, REFILL, WRITE, WDONE.

IDLE:
- cpu_rd & hit: cpu_rdata = line word at offset, same cycle; stall=0.
- cpu_rd & ~hit: stall=1 combinationally; next state REFILL; counter=0.
- cpu_wr: stall=1; next state WRITE. Store has priority if cpu_rd and cpu_wr are both 1.
- No request: stall=0, cpu_rdata=0.

REFILL:
- stall=1, mem_req=1, mem_we=0, mem_addr={tag,index,counter,2'b00}.
- Each mem_ack: write mem_rdata into data[index][counter], then counter+1.
- On the ack with counter=WORDS_PER_LINE-1: set tag and valid on the same edge, go to IDLE.
- The held load then hits. Minimum miss penalty is 5 stall cycles with ack in the same cycle as req.
- mem_req stays high across consecutive words.

WRITE:
- stall=1, mem_req=1, mem_we=1, mem_addr={addr[31:2],2'b00}, mem_wdata=cpu_wdata.
- On mem_ack: if hit, update data[index][offset] with cpu_wdata; go to WDONE.
- Misses do not allocate.

WDONE:
- stall=0 for exactly one cycle so the pipeline retires the store; mem_req=0; next state IDLE.
- Prevents the held store from being written twice.

General rules:
- mem_req, mem_we, mem_addr and mem_wdata are registered/decoded from state, never from mem_ack.
- They remain stable while mem_req=1.
- Reset mid-REFILL or mid-WRITE: mem_req drops on the next edge, state→IDLE, valid bits cleared. A partially filled line is never marked valid.
- Request inputs may change only when stall=0. Behaviour is undefined otherwise.

Decomposition:
- Package dcache_pkg: state enum (IDLE, REFILL, WRITE, WDONE); localparams for offset/index/tag widths derived from LINES and WORDS_PER_LINE.
- Sub-module dcache_array: holds valid/tag/data storage with combinational read, a single write port (word write, tag+valid set, global valid clear), and the hit compare.
- Top level holds the FSM, refill counter and memory interface registers.

Test Plan:
- Reset, then cpu_rd addr 0x100, memory returns 0xA0..0xA3, ack each cycle → stall high 5 cycles; mem_addr 0x100,0x104,0x108,0x10C; then cpu_rdata=0xA0, stall=0.
- After that refill, read 0x108 → same-cycle cpu_rdata=0xA2, stall=0, mem_req never asserted.
- Store 0x55 to 0x104 (hit) → mem_we=1, mem_addr=0x104, mem_wdata=0x55; one WDONE cycle with stall=0; later read 0x104 returns 0x55 with no refill.
- Store to 0x200 (miss) → write-through only; a subsequent read of 0x200 misses and refills.
- Conflict: read 0x100 then 0x500 (LINES=16, same index) → second read refills; re-read of 0x100 misses again.
- Assert reset after 2nd ack of a refill, ack delayed 3 cycles per word → mem_req low next cycle; re-read of same address misses and refills all 4 words.
